// File: rtl/warp_issue_if.sv
// Issue-slot bundle between the warp issue arbiter and the warp-state / fetch side.
// The arbiter owns the master modport; the environment drives through the slave modport.
interface warp_issue_if #(
  parameter int unsigned PcWidth = 5
) ();
  logic [4*PcWidth-1:0] pc_flat;
  logic [3:0]           warp_ready;
  logic [3:0]           warp_done;
  logic                 issue_ready;
  logic [1:0]           select_warp;
  logic                 issue_valid;
  logic [PcWidth-1:0]   issue_pc;
  logic                 all_done;

  modport master (
    input  pc_flat,
    input  warp_ready,
    input  warp_done,
    input  issue_ready,
    output select_warp,
    output issue_valid,
    output issue_pc,
    output all_done
  );

  modport slave (
    output pc_flat,
    output warp_ready,
    output warp_done,
    output issue_ready,
    input  select_warp,
    input  issue_valid,
    input  issue_pc,
    input  all_done
  );
endinterface

// File: rtl/warp_issue_arbiter.sv
// Round-robin issue arbiter over four warps with a per-warp re-issue blackout counter.
// The granted warp's PC is presented to fetch over a valid/ready handshake.
module warp_issue_arbiter #(
  parameter int unsigned PcWidth      = 5,
  parameter int unsigned IssueLatency = 2
) (
  input logic          clk,
  input logic          reset,
  warp_issue_if.master bus
);

  localparam int unsigned    CntW    = (IssueLatency > 0) ? $clog2(IssueLatency + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(IssueLatency);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [0:0] {StEmpty, StHeld} slot_e;

  slot_e           slot_q, slot_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      last_q, last_d;
  logic [3:0]      done_q, done_d;
  logic            all_done_q, all_done_d;
  logic [CntW-1:0] blk_q [4];
  logic [CntW-1:0] blk_d [4];

  logic       fire;
  logic       arb;
  logic [1:0] base;
  logic [3:0] eligible;
  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;

  // The warp being accepted this edge is excluded so the same-edge re-arbitration
  // moves on to another warp; rotation then continues from it.
  always_comb begin
    fire = (slot_q == StHeld) && bus.issue_ready;
    arb  = (slot_q == StEmpty) || bus.issue_ready;
    base = fire ? sel_q : last_q;
    for (int i = 0; i < 4; i++) begin
      eligible[i] = bus.warp_ready[i] && !done_q[i] && (blk_q[i] == '0)
                    && !(fire && (sel_q == 2'(i)));
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = sel_q;
    idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // A held grant is only ever released by acceptance or reset.
  always_comb begin
    slot_d = slot_q;
    sel_d  = sel_q;
    last_d = last_q;
    if (fire) begin
      last_d = sel_q;
    end
    if (arb) begin
      if (found) begin
        slot_d = StHeld;
        sel_d  = winner;
      end else begin
        slot_d = StEmpty;
      end
    end
  end

  always_comb begin
    done_d     = done_q | bus.warp_done;
    all_done_d = &done_d;
    for (int i = 0; i < 4; i++) begin
      blk_d[i] = blk_q[i];
      if (fire && (sel_q == 2'(i))) begin
        blk_d[i] = CntLoad;
      end else if (blk_q[i] != '0) begin
        blk_d[i] = blk_q[i] - CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q     <= StEmpty;
      sel_q      <= 2'd0;
      last_q     <= 2'd3;
      done_q     <= 4'b0000;
      all_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        blk_q[i] <= '0;
      end
    end else begin
      slot_q     <= slot_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      done_q     <= done_d;
      all_done_q <= all_done_d;
      for (int i = 0; i < 4; i++) begin
        blk_q[i] <= blk_d[i];
      end
    end
  end

  assign bus.select_warp = sel_q;
  assign bus.issue_valid = (slot_q == StHeld);
  assign bus.all_done    = all_done_q;
  assign bus.issue_pc    = bus.pc_flat[sel_q*PcWidth +: PcWidth];

endmodule
